output_port_allocator: RTL and testbench
========================================

Name: output_port_allocator

Overview:
- Per-output-port packet-level (wormhole) allocator for the 5-port NoC router.
- Arbitrates between the five input ports (L, N, E, W, S) requesting one output. Only header flits can win.
- Locks the output to the winning input until its packet completes, then advances a round-robin pointer.
- Drives the FIFO read-enable grants and the crossbar select lines for its output. The router has one instance per output port.

Parameters:
- NPORTS, 5, number of input requesters; index order L=0, N=1, E=2, W=3, S=4 (same as xbar sel bits).
- ID_W, 3, flit-id field width.
- LEN_W, 12, packet-length field width (total flits, header included).
- TIMEOUT, 1024, maximum stall cycles while locked before the lock is forcibly released.
- TO_W, 10, width of the watchdog counter; TO_W must be at least ceil(log2(TIMEOUT)).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req  in  NPORTS  per-input request for this output (flowcontrol ready_out).
- flit_id  in  NPORTS*ID_W  packed flit ids at the FIFO heads; input i occupies bits [i*ID_W +: ID_W].
- pkt_len  in  NPORTS*LEN_W  packed length fields at the FIFO heads.
- dcts  in  1  downstream clear-to-send for this output.
- grant  out  NPORTS  one-hot read enable to the owner FIFO; one flit moves per asserted cycle.
- sel  out  NPORTS  one-hot crossbar select; held for the whole packet.
- busy  out  1  output locked.
- pkt_done  out  1  one-cycle pulse after the final flit.
- err_timeout  out  1  one-cycle pulse on watchdog release.

Behaviour:
- Flit ids: HEADER=3'b001, BODY=3'b010, TAIL=3'b100. All other codes are treated as BODY.
- Reset: state=IDLE, owner=0, rr_ptr=0, cnt=0, wdog=0. grant, sel, busy, pkt_done and err_timeout are all 0. Reset mid-packet aborts the lock; grant is 0 in the cycle after rst is sampled.
- IDLE:
  - Candidate i requires req[i]=1 and flit_id[i]=HEADER. Requests carrying non-header flits are ignored.
  - Winner is the first candidate scanning rr_ptr, rr_ptr+1, ... mod NPORTS.
  - On a winner, at the next edge: state=ACTIVE, owner=winner, cnt=pkt_len[winner], wdog=0.
  - The arbitration cycle issues no grant (1-cycle arbitration latency).
- ACTIVE:
  - sel=onehot(owner) and busy=1.
  - grant=onehot(owner) only when dcts=1 and req[owner]=1. grant is combinational from registered state and the current inputs.
  - Each grant cycle: cnt<=cnt-1 and wdog<=0.
  - Release condition: a grant cycle where cnt<=1 or flit_id[owner]=TAIL. On release, at the next edge: state=IDLE, rr_ptr=(owner+1) mod NPORTS, pkt_done=1 for one cycle.
  - pkt_len of 0 or 1 means a header-only packet, released after one flit.
- Stall in ACTIVE (dcts=0 or req[owner]=0):
  - No grant; cnt is held; wdog increments.
  - When wdog reaches TIMEOUT-1 and the cycle is still stalled: state=IDLE, rr_ptr=(owner+1) mod NPORTS, err_timeout=1 for one cycle, pkt_done=0.
- Back-to-back packets: release costs one IDLE cycle, so the minimum gap between the last flit of one packet and the first flit of the next is 1 cycle.
- Fairness: a requester waits at most NPORTS-1 packets before being granted.
- Width rules:
  - cnt is LEN_W bits and never underflows; the decrement is suppressed at 0.
  - wdog saturates at TIMEOUT-1.
  - rr_ptr wraps from 4 to 0.
- Invariant: grant and sel are always one-hot or zero; grant is a subset of sel.

Decomposition:
- Shared package / include (alongside parameters.v):
  - flit-id constants FLIT_HEADER, FLIT_BODY, FLIT_TAIL;
  - state encodings ALLOC_IDLE, ALLOC_ACTIVE;
  - port index constants PORT_L..PORT_S.
- Sub-module rr_pick: combinational round-robin priority picker. Inputs are the candidate vector and rr_ptr; outputs are a one-hot winner and a valid flag.
- The FSM, length counter and watchdog stay in output_port_allocator.

Test Plan:
- Single packet: req[2]=1 (E), header with pkt_len=4, dcts=1 throughout -> grant=5'b00100 for exactly 4 consecutive cycles starting 1 cycle after the request; pkt_done pulses the next cycle; rr_ptr=3.
- Contention: all five inputs present headers with len=2, starting with rr_ptr=0 -> packets granted in order L, N, E, W, S; each packet gets 2 grant cycles followed by a 1-cycle gap.
- Backpressure: owner N with len=3, dcts dropped for 5 cycles after the first flit -> grant=0 and sel=5'b00010 held during the stall; exactly 3 grants in total; no err_timeout.
- Early tail: len=8 but flit_id=TAIL on the 3rd flit -> release after 3 grants; pkt_done pulses once.
- Watchdog: TIMEOUT=16, owner W with req[3] held low after the header -> err_timeout pulses on stall cycle 16; busy=0; the next header from S is granted.
- Reset mid-packet: rst=1 during flit 2 of 6 -> all outputs 0 the next cycle; after rst deasserts, rr_ptr=0 and L wins over a simultaneous S header.

Source files
------------

// File: rtl/output_port_allocator_pkg.sv
// Shared constants for the per-output wormhole allocator.
// Flit ids, FSM states and input-port indices.
package output_port_allocator_pkg;

  localparam int FLIT_W = 3;

  localparam logic [FLIT_W-1:0] FLIT_HEADER = 3'b001;
  localparam logic [FLIT_W-1:0] FLIT_BODY   = 3'b010;
  localparam logic [FLIT_W-1:0] FLIT_TAIL   = 3'b100;

  localparam int PORT_L = 0;
  localparam int PORT_N = 1;
  localparam int PORT_E = 2;
  localparam int PORT_W = 3;
  localparam int PORT_S = 4;

  typedef enum logic {
    ALLOC_IDLE   = 1'b0,
    ALLOC_ACTIVE = 1'b1
  } alloc_state_e;

endpackage

// File: rtl/output_port_allocator_rr_pick.sv
// Round-robin priority picker: first set candidate at or after ptr.
// Produces a one-hot winner plus a valid flag.
module output_port_allocator_rr_pick #(
  parameter int NPORTS = 5,
  parameter int PTR_W  = 3
) (
  input  logic [NPORTS-1:0] cand,
  input  logic [PTR_W-1:0]  ptr,
  output logic [NPORTS-1:0] win,
  output logic              valid
);

  int idx;

  // Scan ptr, ptr+1, ... mod NPORTS and keep the first hit
  always_comb begin
    win   = '0;
    valid = 1'b0;
    idx   = 0;
    for (int k = 0; k < NPORTS; k++) begin
      idx = (int'(ptr) + k) % NPORTS;
      if (!valid && cand[idx]) begin
        win[idx] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/output_port_allocator.sv
// Per-output wormhole allocator: locks the output to one input
// for a whole packet, with round-robin fairness and a watchdog.
module output_port_allocator
  import output_port_allocator_pkg::*;
#(
  parameter int NPORTS  = 5,
  parameter int ID_W    = 3,
  parameter int LEN_W   = 12,
  parameter int TIMEOUT = 1024,
  parameter int TO_W    = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NPORTS-1:0]       req,
  input  logic [NPORTS*ID_W-1:0]  flit_id,
  input  logic [NPORTS*LEN_W-1:0] pkt_len,
  input  logic                    dcts,
  output logic [NPORTS-1:0]       grant,
  output logic [NPORTS-1:0]       sel,
  output logic                    busy,
  output logic                    pkt_done,
  output logic                    err_timeout
);

  localparam int PTR_W = $clog2(NPORTS);
  localparam logic [TO_W-1:0] WD_MAX = TO_W'(TIMEOUT - 1);
  localparam logic [NPORTS-1:0] ONE = NPORTS'(1);

  alloc_state_e      state;
  logic [PTR_W-1:0]  owner;
  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  next_ptr;
  logic [PTR_W-1:0]  win_idx;
  logic [LEN_W-1:0]  cnt;
  logic [TO_W-1:0]   wdog;
  logic [ID_W-1:0]   ids  [NPORTS];
  logic [LEN_W-1:0]  lens [NPORTS];
  logic [NPORTS-1:0] cand;
  logic [NPORTS-1:0] win;
  logic              win_valid;
  logic [NPORTS-1:0] own_oh;
  logic              grant_en;
  logic              last;

  // Unpack the FIFO-head fields and form header-only candidates
  always_comb begin
    cand = '0;
    for (int i = 0; i < NPORTS; i++) begin
      ids[i]  = flit_id[i*ID_W +: ID_W];
      lens[i] = pkt_len[i*LEN_W +: LEN_W];
      cand[i] = req[i] && (ids[i] == ID_W'(FLIT_HEADER));
    end
  end

  output_port_allocator_rr_pick #(
    .NPORTS (NPORTS),
    .PTR_W  (PTR_W)
  ) u_pick (
    .cand  (cand),
    .ptr   (rr_ptr),
    .win   (win),
    .valid (win_valid)
  );

  // Convert the one-hot winner into an owner index
  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NPORTS; i++) begin
      if (win[i]) win_idx = PTR_W'(i);
    end
  end

  assign own_oh   = ONE << owner;
  assign busy     = (state == ALLOC_ACTIVE);
  assign sel      = busy ? own_oh : '0;
  assign grant_en = busy && dcts && req[owner];
  assign grant    = grant_en ? own_oh : '0;
  assign last     = (cnt <= LEN_W'(1)) ||
                    (ids[owner] == ID_W'(FLIT_TAIL));
  assign next_ptr = (owner == PTR_W'(NPORTS - 1)) ?
                    '0 : owner + PTR_W'(1);

  // Lock FSM with length counter, watchdog and pulse outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ALLOC_IDLE;
      owner       <= '0;
      rr_ptr      <= '0;
      cnt         <= '0;
      wdog        <= '0;
      pkt_done    <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      pkt_done    <= 1'b0;
      err_timeout <= 1'b0;
      unique case (state)
        ALLOC_IDLE: begin
          if (win_valid) begin
            state <= ALLOC_ACTIVE;
            owner <= win_idx;
            cnt   <= lens[win_idx];
            wdog  <= '0;
          end
        end
        ALLOC_ACTIVE: begin
          if (grant_en) begin
            wdog <= '0;
            if (cnt != '0) cnt <= cnt - LEN_W'(1);
            if (last) begin
              state    <= ALLOC_IDLE;
              rr_ptr   <= next_ptr;
              pkt_done <= 1'b1;
            end
          end else if (wdog == WD_MAX) begin
            state       <= ALLOC_IDLE;
            rr_ptr      <= next_ptr;
            err_timeout <= 1'b1;
          end else begin
            wdog <= wdog + TO_W'(1);
          end
        end
        default: state <= ALLOC_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_output_port_allocator.sv
// Directed bench for output_port_allocator.
// Watchdog shortened to 16 cycles.
module tb_output_port_allocator;
  import output_port_allocator_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  req;
  logic [14:0] flit_id;
  logic [59:0] pkt_len;
  logic        dcts;
  logic [4:0]  grant;
  logic [4:0]  sel;
  logic        busy;
  logic        pkt_done;
  logic        err_timeout;

  int checks = 0;
  int errors = 0;

  output_port_allocator #(
    .NPORTS  (5),
    .ID_W    (3),
    .LEN_W   (12),
    .TIMEOUT (16),
    .TO_W    (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .flit_id     (flit_id),
    .pkt_len     (pkt_len),
    .dcts        (dcts),
    .grant       (grant),
    .sel         (sel),
    .busy        (busy),
    .pkt_done    (pkt_done),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic set_flit(input int i,
                          input logic [2:0] id,
                          input logic [11:0] len);
    flit_id[i*3 +: 3]  = id;
    pkt_len[i*12 +: 12] = len;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant"}, 32'(grant), 0);
    chk({tag, "_sel"}, 32'(sel), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(pkt_done), 0);
    chk({tag, "_tmo"}, 32'(err_timeout), 0);
  endtask

  initial begin
    rst     = 1'b1;
    req     = '0;
    flit_id = '0;
    pkt_len = '0;
    dcts    = 1'b0;
    tick();
    tick();
    #1;
    chk_all_zero("reset");
    rst = 1'b0;

    // Single packet from E, length 4
    req  = 5'b00100;
    dcts = 1'b1;
    set_flit(PORT_E, FLIT_HEADER, 12'd4);
    #1;
    chk("t1_arb_grant", 32'(grant), 0);
    chk("t1_arb_busy", 32'(busy), 0);
    tick();
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t1_grant", 32'(grant), 32'h04);
      chk("t1_sel", 32'(sel), 32'h04);
      tick();
      set_flit(PORT_E, FLIT_BODY, 12'd4);
    end
    #1;
    chk("t1_done", 32'(pkt_done), 1);
    chk("t1_rel_grant", 32'(grant), 0);
    chk("t1_rel_busy", 32'(busy), 0);
    chk("t1_rr_ptr", 32'(dut.rr_ptr), 3);
    req = '0;
    tick();
    #1;
    chk("t1_done_pulse", 32'(pkt_done), 0);

    // Contention: reset pointer, all five headers len 2
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 5'b11111;
    for (int i = 0; i < 5; i++)
      set_flit(i, FLIT_HEADER, 12'd2);
    for (int p = 0; p < 5; p++) begin
      #1;
      chk("t2_gap_grant", 32'(grant), 0);
      tick();
      #1;
      chk("t2_grant1", 32'(grant), 32'(1 << p));
      tick();
      set_flit(p, FLIT_BODY, 12'd2);
      #1;
      chk("t2_grant2", 32'(grant), 32'(1 << p));
      tick();
      req[p] = 1'b0;
      #1;
      chk("t2_done", 32'(pkt_done), 1);
    end
    chk("t2_rr_wrap", 32'(dut.rr_ptr), 0);

    // Backpressure: owner N, len 3, dcts low 5 cycles
    req = 5'b00010;
    set_flit(PORT_N, FLIT_HEADER, 12'd3);
    tick();
    #1;
    chk("t3_flit1", 32'(grant), 32'h02);
    tick();
    set_flit(PORT_N, FLIT_BODY, 12'd3);
    dcts = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t3_stall_grant", 32'(grant), 0);
      chk("t3_stall_sel", 32'(sel), 32'h02);
      chk("t3_stall_tmo", 32'(err_timeout), 0);
      tick();
    end
    dcts = 1'b1;
    #1;
    chk("t3_flit2", 32'(grant), 32'h02);
    tick();
    #1;
    chk("t3_flit3", 32'(grant), 32'h02);
    tick();
    #1;
    chk("t3_done", 32'(pkt_done), 1);
    chk("t3_busy", 32'(busy), 0);
    chk("t3_tmo", 32'(err_timeout), 0);
    chk("t3_rr_ptr", 32'(dut.rr_ptr), 2);
    req = '0;

    // Early tail: S, len 8, tail on 3rd flit
    req = 5'b10000;
    set_flit(PORT_S, FLIT_HEADER, 12'd8);
    tick();
    #1;
    chk("t4_flit1", 32'(grant), 32'h10);
    tick();
    set_flit(PORT_S, FLIT_BODY, 12'd8);
    #1;
    chk("t4_flit2", 32'(grant), 32'h10);
    tick();
    set_flit(PORT_S, FLIT_TAIL, 12'd8);
    #1;
    chk("t4_flit3", 32'(grant), 32'h10);
    tick();
    set_flit(PORT_S, FLIT_BODY, 12'd8);
    #1;
    chk("t4_done", 32'(pkt_done), 1);
    chk("t4_busy", 32'(busy), 0);
    chk("t4_grant", 32'(grant), 0);
    req = '0;
    tick();
    #1;
    chk("t4_done_once", 32'(pkt_done), 0);

    // Watchdog: owner W stalls after header
    req = 5'b01000;
    set_flit(PORT_W, FLIT_HEADER, 12'd5);
    tick();
    #1;
    chk("t5_flit1", 32'(grant), 32'h08);
    tick();
    req = '0;
    set_flit(PORT_W, FLIT_BODY, 12'd5);
    for (int k = 1; k <= 16; k++) begin
      #1;
      chk("t5_stall_busy", 32'(busy), 1);
      chk("t5_stall_tmo", 32'(err_timeout), 0);
      tick();
    end
    #1;
    chk("t5_tmo", 32'(err_timeout), 1);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_done", 32'(pkt_done), 0);
    req = 5'b10000;
    set_flit(PORT_S, FLIT_HEADER, 12'd1);
    tick();
    #1;
    chk("t5_tmo_pulse", 32'(err_timeout), 0);
    chk("t5_s_grant", 32'(grant), 32'h10);
    tick();
    req = '0;
    #1;
    chk("t5_s_done", 32'(pkt_done), 1);

    // Reset mid-packet: move pointer to 2, then abort W
    req = 5'b00010;
    set_flit(PORT_N, FLIT_HEADER, 12'd1);
    tick();
    #1;
    chk("t6_n_grant", 32'(grant), 32'h02);
    tick();
    req = 5'b01000;
    set_flit(PORT_W, FLIT_HEADER, 12'd6);
    #1;
    chk("t6_rr_ptr", 32'(dut.rr_ptr), 2);
    tick();
    #1;
    chk("t6_w_flit1", 32'(grant), 32'h08);
    tick();
    set_flit(PORT_W, FLIT_BODY, 12'd6);
    rst = 1'b1;
    tick();
    #1;
    chk_all_zero("t6_rst");
    rst = 1'b0;
    req = 5'b10001;
    set_flit(PORT_L, FLIT_HEADER, 12'd2);
    set_flit(PORT_S, FLIT_HEADER, 12'd2);
    #1;
    chk("t6_rr_cleared", 32'(dut.rr_ptr), 0);
    chk("t6_arb_grant", 32'(grant), 0);
    tick();
    #1;
    chk("t6_l_wins", 32'(grant), 32'h01);
    chk("t6_l_sel", 32'(sel), 32'h01);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
